// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward codes,
// result-latency / operand-use constants and the scoreboard entry layout.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_M    = 2'd1,
      FWD_W    = 2'd2,
      FWD_E    = 2'd3
   } fwd_t;

   localparam logic [1:0] TNEW_LOAD  = 2'd2;
   localparam logic [1:0] TNEW_ALU   = 2'd1;
   localparam logic [1:0] TNEW_LINK  = 2'd0;

   localparam logic [1:0] TUSE_BR    = 2'd0;
   localparam logic [1:0] TUSE_ALU   = 2'd1;
   localparam logic [1:0] TUSE_STORE = 2'd2;

   typedef struct packed {
      logic [4:0] tar;
      logic [1:0] tnew;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       md;
      logic       md_div;
   } sb_entry_t;

   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Mult/div busy down-counter: reloads when a mult/div sits in E, otherwise
// counts down to zero; busy while non-zero.
module md_busy_ctr #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic start_div,
   output logic busy
);

   localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   logic [CW-1:0] cnt;

   // A new mult/div in E always wins over an in-flight count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (start && start_div) begin
         cnt <= CW'(DIV_CYC);
      end else if (start) begin
         cnt <= CW'(MULT_CYC);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: E/M/W destination scoreboard with Tnew,
// D-stage stall generation and D/E/M operand forwarding selects.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic       d_cal_reg,
   input  logic       d_cal_imm,
   input  logic       d_load,
   input  logic       d_store,
   input  logic       d_branch,
   input  logic       d_jr,
   input  logic       d_link,
   input  logic       d_md,
   input  logic       d_load_hilo,
   input  logic       d_store_hilo,
   input  logic       d_md_div,
   input  logic [4:0] d_tar,
   output logic       stall,
   output logic [1:0] fwd_d_rs,
   output logic [1:0] fwd_d_rt,
   output logic [1:0] fwd_e_rs,
   output logic [1:0] fwd_e_rt,
   output logic [1:0] fwd_m_rt,
   output logic       md_busy
);

   sb_entry_t sb_e, sb_m, sb_w;
   sb_entry_t d_ent;

   logic       rs_used, rt_used;
   logic [1:0] tuse_rs, tuse_rt;
   logic       stall_rs, stall_rt, stall_md;

   always_comb begin
      rs_used = 1'b0;
      rt_used = 1'b0;
      tuse_rs = TUSE_BR;
      tuse_rt = TUSE_BR;
      if (d_branch || d_jr) begin
         rs_used = 1'b1;
         rt_used = 1'b1;
      end else if (d_cal_reg || d_md) begin
         rs_used = 1'b1;
         rt_used = 1'b1;
         tuse_rs = TUSE_ALU;
         tuse_rt = TUSE_ALU;
      end else if (d_cal_imm || d_load || d_store || d_store_hilo) begin
         rs_used = 1'b1;
         tuse_rs = TUSE_ALU;
      end
      if (d_store) begin
         rt_used = 1'b1;
         tuse_rt = TUSE_STORE;
      end
   end

   // Instructions that produce nothing enter E with tar=0 so they never match.
   always_comb begin
      d_ent        = '0;
      d_ent.rs     = d_rs;
      d_ent.rt     = d_rt;
      d_ent.md     = d_md;
      d_ent.md_div = d_md && d_md_div;
      if (d_load) begin
         d_ent.tar  = d_tar;
         d_ent.tnew = TNEW_LOAD;
      end else if (d_cal_reg || d_cal_imm || d_load_hilo) begin
         d_ent.tar  = d_tar;
         d_ent.tnew = TNEW_ALU;
      end else if (d_link) begin
         d_ent.tar  = d_tar;
         d_ent.tnew = TNEW_LINK;
      end
   end

   function automatic logic op_hazard(input logic [4:0] r, input logic used,
                                      input logic [1:0] tuse,
                                      input sb_entry_t e, input sb_entry_t m);
      return used && (r != 5'd0) &&
             (((e.tar == r) && (e.tnew > tuse)) ||
              ((m.tar == r) && (m.tnew > tuse)));
   endfunction

   assign stall_rs = op_hazard(d_rs, rs_used, tuse_rs, sb_e, sb_m);
   assign stall_rt = op_hazard(d_rt, rt_used, tuse_rt, sb_e, sb_m);
   assign stall_md = (d_md || d_load_hilo || d_store_hilo) && (sb_e.md || md_busy);
   assign stall    = stall_rs || stall_rt || stall_md;

   // Nearest matching stage decides; if its result is not ready yet, no forward.
   function automatic logic [1:0] fwd_d_sel(input logic [4:0] r, input sb_entry_t e,
                                            input sb_entry_t m, input sb_entry_t w);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (r == 5'd0)       sel = FWD_NONE;
      else if (e.tar == r) sel = (e.tnew == 2'd0) ? FWD_E : FWD_NONE;
      else if (m.tar == r) sel = (m.tnew == 2'd0) ? FWD_M : FWD_NONE;
      else if (w.tar == r) sel = (w.tnew == 2'd0) ? FWD_W : FWD_NONE;
      return sel;
   endfunction

   function automatic logic [1:0] fwd_mw_sel(input logic [4:0] r, input sb_entry_t m,
                                             input sb_entry_t w);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (r == 5'd0)       sel = FWD_NONE;
      else if (m.tar == r) sel = (m.tnew == 2'd0) ? FWD_M : FWD_NONE;
      else if (w.tar == r) sel = (w.tnew == 2'd0) ? FWD_W : FWD_NONE;
      return sel;
   endfunction

   assign fwd_d_rs = fwd_d_sel(d_rs, sb_e, sb_m, sb_w);
   assign fwd_d_rt = fwd_d_sel(d_rt, sb_e, sb_m, sb_w);
   assign fwd_e_rs = fwd_mw_sel(sb_e.rs, sb_m, sb_w);
   assign fwd_e_rt = fwd_mw_sel(sb_e.rt, sb_m, sb_w);

   always_comb begin
      fwd_m_rt = FWD_NONE;
      if ((sb_m.rt != 5'd0) && (sb_w.tar == sb_m.rt) && (sb_w.tnew == 2'd0))
         fwd_m_rt = FWD_W;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sb_e <= '0;
         sb_m <= '0;
         sb_w <= '0;
      end else begin
         sb_w      <= sb_m;
         sb_w.tnew <= tnew_dec(sb_m.tnew);
         sb_m      <= sb_e;
         sb_m.tnew <= tnew_dec(sb_e.tnew);
         sb_e      <= stall ? '0 : d_ent;
      end
   end

   // Fields carried down the pipe for visibility but not consumed in M/W.
   logic unused_sb_bits;
   assign unused_sb_bits = ^{sb_m.rs, sb_m.md, sb_m.md_div,
                             sb_w.rs, sb_w.rt, sb_w.md, sb_w.md_div};

   md_busy_ctr #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_busy_ctr (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (sb_e.md),
      .start_div (sb_e.md_div),
      .busy      (md_busy)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instruction pairs with hand-derived
// stall/forward/busy expectations, sampled on the falling edge.
module tb_hazard_ctrl;

   logic       clk;
   logic       reset_n;
   logic [4:0] d_rs, d_rt, d_tar;
   logic       d_cal_reg, d_cal_imm, d_load, d_store, d_branch, d_jr, d_link;
   logic       d_md, d_load_hilo, d_store_hilo, d_md_div;
   logic       stall, md_busy;
   logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

   int checks   = 0;
   int failures = 0;

   localparam int K_NOP = 0, K_CALR = 1, K_CALI = 2, K_LOAD = 3, K_STORE = 4,
                  K_BR = 5, K_JR = 6, K_JAL = 7, K_MULT = 8, K_DIV = 9,
                  K_MFHI = 10, K_MTHI = 11;

   hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .d_rs         (d_rs),
      .d_rt         (d_rt),
      .d_cal_reg    (d_cal_reg),
      .d_cal_imm    (d_cal_imm),
      .d_load       (d_load),
      .d_store      (d_store),
      .d_branch     (d_branch),
      .d_jr         (d_jr),
      .d_link       (d_link),
      .d_md         (d_md),
      .d_load_hilo  (d_load_hilo),
      .d_store_hilo (d_store_hilo),
      .d_md_div     (d_md_div),
      .d_tar        (d_tar),
      .stall        (stall),
      .fwd_d_rs     (fwd_d_rs),
      .fwd_d_rt     (fwd_d_rt),
      .fwd_e_rs     (fwd_e_rs),
      .fwd_e_rt     (fwd_e_rt),
      .fwd_m_rt     (fwd_m_rt),
      .md_busy      (md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_i(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] tar);
      d_rs = rs; d_rt = rt; d_tar = tar;
      d_cal_reg = (kind == K_CALR);
      d_cal_imm = (kind == K_CALI);
      d_load = (kind == K_LOAD);
      d_store = (kind == K_STORE);
      d_branch = (kind == K_BR);
      d_jr = (kind == K_JR);
      d_link = (kind == K_JAL);
      d_md = (kind == K_MULT) || (kind == K_DIV);
      d_md_div = (kind == K_DIV);
      d_load_hilo = (kind == K_MFHI);
      d_store_hilo = (kind == K_MTHI);
   endtask

   task automatic next;
      @(posedge clk);
      #1;
   endtask

   task automatic flush;
      set_i(K_NOP, 0, 0, 0);
      repeat (4) next;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_stall"}, stall, 0);
      check({tag, "_busy"}, md_busy, 0);
      check({tag, "_fdrs"}, fwd_d_rs, 0);
      check({tag, "_fdrt"}, fwd_d_rt, 0);
      check({tag, "_fers"}, fwd_e_rs, 0);
      check({tag, "_fert"}, fwd_e_rt, 0);
      check({tag, "_fmrt"}, fwd_m_rt, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      set_i(K_NOP, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      // after reset, even a consumer of $1 sees an empty scoreboard
      set_i(K_CALR, 1, 2, 3);
      @(negedge clk);
      check_quiet("rst");
      next;
      flush;

      // lw $1 ; add $3,$1,$2
      set_i(K_LOAD, 29, 0, 1);
      @(negedge clk); check("lw_c0_stall", stall, 0);
      next;
      set_i(K_CALR, 1, 2, 3);
      @(negedge clk); check("lwadd_c1_stall", stall, 1);
      next;
      @(negedge clk); check("lwadd_c2_stall", stall, 0);
      check("lwadd_c2_fdrs", fwd_d_rs, 0);
      next;
      set_i(K_NOP, 0, 0, 0);
      @(negedge clk); check("lwadd_c3_fers", fwd_e_rs, 2);
      check("lwadd_c3_fert", fwd_e_rt, 0);
      flush;

      // addi $4 ; beq $4,$5
      set_i(K_CALI, 0, 0, 4);
      @(negedge clk); check("addi_c0_stall", stall, 0);
      next;
      set_i(K_BR, 4, 5, 0);
      @(negedge clk); check("beq_c1_stall", stall, 1);
      next;
      @(negedge clk); check("beq_c2_stall", stall, 0);
      check("beq_c2_fdrs", fwd_d_rs, 1);
      check("beq_c2_fdrt", fwd_d_rt, 0);
      flush;

      // jal ; jr $31
      set_i(K_JAL, 0, 0, 31);
      next;
      set_i(K_JR, 31, 0, 0);
      @(negedge clk); check("jr_stall", stall, 0);
      check("jr_fdrs", fwd_d_rs, 3);
      flush;

      // addi $6 ; add $7,$6,$6 : no stall, forwarded from M once in E
      set_i(K_CALI, 0, 0, 6);
      next;
      set_i(K_CALR, 6, 6, 7);
      @(negedge clk); check("add6_c1_stall", stall, 0);
      check("add6_c1_fdrs", fwd_d_rs, 0);
      next;
      set_i(K_NOP, 0, 0, 0);
      @(negedge clk); check("add6_c2_fers", fwd_e_rs, 1);
      check("add6_c2_fert", fwd_e_rt, 1);
      flush;

      // lw $1 ; sw $1 : store data Tuse=2 never stalls, data via M<-W
      set_i(K_LOAD, 29, 0, 1);
      next;
      set_i(K_STORE, 29, 1, 0);
      @(negedge clk); check("sw_c1_stall", stall, 0);
      check("sw_c1_fdrt", fwd_d_rt, 0);
      next;
      set_i(K_NOP, 0, 0, 0);
      @(negedge clk); check("sw_c2_fert", fwd_e_rt, 0);
      next;
      @(negedge clk); check("sw_c3_fmrt", fwd_m_rt, 2);
      flush;

      // mult ; mfhi : stall cycles 1-6, busy cycles 2-6
      set_i(K_MULT, 8, 9, 0);
      @(negedge clk); check("mult_c0_stall", stall, 0);
      check("mult_c0_busy", md_busy, 0);
      next;
      set_i(K_MFHI, 0, 0, 10);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         check($sformatf("mfhi_c%0d_stall", c), stall, (c <= 6) ? 1 : 0);
         check($sformatf("mfhi_c%0d_busy", c), md_busy, (c >= 2 && c <= 6) ? 1 : 0);
         next;
      end
      flush;

      // addi $0,$0,1 ; add $2,$0,$0 : register zero never stalls or forwards
      set_i(K_CALI, 0, 0, 0);
      next;
      set_i(K_CALR, 0, 0, 2);
      @(negedge clk); check("zero_c1_stall", stall, 0);
      check("zero_c1_fdrs", fwd_d_rs, 0);
      check("zero_c1_fdrt", fwd_d_rt, 0);
      next;
      set_i(K_NOP, 0, 0, 0);
      @(negedge clk); check("zero_c2_fers", fwd_e_rs, 0);
      check("zero_c2_fert", fwd_e_rt, 0);
      flush;

      // div, then reset while busy aborts the count
      set_i(K_DIV, 8, 9, 0);
      next;
      set_i(K_NOP, 0, 0, 0);
      next;
      set_i(K_MFHI, 0, 0, 11);
      @(negedge clk); check("div_c2_busy", md_busy, 1);
      check("div_c2_stall", stall, 1);
      reset_n = 1'b0;
      next;
      reset_n = 1'b1;
      @(negedge clk); check("div_rst_busy", md_busy, 0);
      check("div_rst_stall", stall, 0);
      next;
      set_i(K_NOP, 0, 0, 0);
      @(negedge clk); check("div_rst2_busy", md_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It consumes the D-stage instruction classification and destination register from the per-instruction judge decoder. It keeps a registered scoreboard of the E/M/W destinations with their remaining result latency (Tnew), and generates the D-stage stall/bubble request and operand forwarding selects for D, E and M. It also owns the mult/div busy counter that stalls HI/LO-class instructions.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu leaves E
- DIV_CYC, 10, busy cycles after a div/divu leaves E

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- d_rs, d_rt  in  5 each  D-stage source register fields
- d_cal_reg, d_cal_imm, d_load, d_store, d_branch, d_jr, d_link, d_md, d_load_hilo, d_store_hilo  in  1 each  D-stage class flags (mutually exclusive except d_link with d_jr)
- d_md_div  in  1  D-stage md instruction is a divide
- d_tar  in  5  D-stage destination register (0 = none)
- stall  out  1  hold PC/D, insert bubble into E
- fwd_d_rs, fwd_d_rt  out  2 each  D-stage operand source
- fwd_e_rs, fwd_e_rt  out  2 each  E-stage operand source
- fwd_m_rt  out  2  M-stage store-data source
- md_busy  out  1  busy counter non-zero

## Operation
- Forward codes: 0 = no forward, 1 = from M, 2 = from W, 3 = from E (D consumers only).
- Tuse, combinational from D flags:
  - branch/jr: rs and rt = 0
  - cal_reg/md: rs and rt = 1
  - cal_imm/load/store/store_hilo: rs = 1
  - store: rt = 2
  - An operand with no use is ignored.
- Tnew written into the E entry:
  - load = 2
  - cal_reg/cal_imm/load_hilo = 1
  - link = 0
  - otherwise the destination is forced to 0
- Scoreboard entries E, M, W each hold {tar, tnew, rs, rt, md, md_div}. Each clock: W←M, M←E with tnew decremented, saturating at 0.
- E←D fields when stall=0; E←bubble (all zero) when stall=1.
- Stall rule, for each used D operand r with r≠0:
  - stall if E.tar==r and E.tnew>Tuse(r), or if M.tar==r and M.tnew>Tuse(r).
  - Also stall if the D instruction is md/load_hilo/store_hilo and (E.md or md_busy).
- D forwarding: nearest matching stage with tnew==0, priority E, then M, then W; r==0 gives 0.
- E forwarding uses E.rs/E.rt against M, then W.
- M forwarding uses M.rt against W.
- Busy counter:
  - loads DIV_CYC if E.md&&E.md_div, else MULT_CYC if E.md.
  - otherwise decrements while non-zero.
  - md_busy = counter≠0.

## Timing
- stall and all fwd_* are combinational from D inputs and registered state, valid in the same cycle.
- Scoreboard and counter update on the rising clk edge.
- Reset: when reset_n=0 at an edge, all entries and the counter clear. In the cycle after, stall=0, md_busy=0 and all fwd_*=0 unless the current D inputs demand otherwise; with the scoreboard empty, D inputs cannot cause a stall or forward.
- Reset mid-operation (e.g. during a div) aborts busy immediately.
- A stalled instruction re-evaluates every cycle. Its release occurs in the first cycle where the stall condition is false.
- Simultaneous rs and rt hazards: a single stall covers both. Forwarding is resolved per operand independently.
- When both E.md and a non-zero counter are present, E.md wins: the counter reloads.

## Structure
- hazard_pkg:
  - forward codes FWD_NONE/FWD_M/FWD_W/FWD_E
  - Tnew/Tuse constants
  - the scoreboard entry struct typedef
- Sub-module md_busy_ctr: counter with load/decrement and a busy flag, parameterised by MULT_CYC/DIV_CYC.
- hazard_ctrl instantiates md_busy_ctr. It contains the scoreboard registers and the comparison logic.

## Test plan
- lw $1 in D at cycle 0, add $3,$1,$2 in D at cycle 1:
  - stall=1 in cycle 1 only.
  - In cycle 3, with add in E and lw in W, fwd_e_rs=2.
- addi $4 then beq $4,$5:
  - stall=1 for one cycle.
  - Next cycle fwd_d_rs=1 (from M).
- jal then jr $31 back-to-back: stall=0, fwd_d_rs=3 (from E).
- mult in D at cycle 0, mfhi in D at cycle 1:
  - stall=1 for cycles 1–6.
  - md_busy=1 for cycles 2–6.
  - stall=0 in cycle 7.
- addi $0,$0,1 followed by add $2,$0,$0: stall=0, fwd_d_rs=fwd_d_rt=0 and fwd_e_rs=fwd_e_rt=0.
- div issued, then reset_n=0 for one edge during busy: next cycle md_busy=0 and stall=0; a subsequent mflo is not stalled.
